// File: rtl/bch63_syndrome.sv
// Odd-syndrome generator for the (63,51) t=2 binary BCH code over GF(2^6),
// primitive polynomial x^6+x+1. Hard bits arrive 8 per beat, highest degrees
// first, and are folded into S1 = r(a) and S3 = r(a^3) by a Horner update.
// The finished syndromes sit in a valid/ready output register.

// One syndrome lane: acc_next = acc_in * a^(8J) + sum_k bits[k] * a^(J*k).
// Every product is by a constant power of a, so each term collapses to a
// fixed XOR network; there is no general field multiplier.
module bch63_syn_lane #(
  parameter int J      = 1,
  parameter int GF_M   = 6,
  parameter int BEAT_W = 8
) (
  input  logic [BEAT_W-1:0] bits,
  input  logic [GF_M-1:0]   acc_in,
  output logic [GF_M-1:0]   acc_next
);
  // Reduction term for x^GF_M under x^6+x+1.
  localparam logic [GF_M-1:0] POLY_LO = GF_M'(3);

  function automatic logic [GF_M-1:0] mulx(input logic [GF_M-1:0] v);
    return {v[GF_M-2:0], 1'b0} ^ (v[GF_M-1] ? POLY_LO : '0);
  endfunction

  // Multiply by a^p; p is always an elaboration constant here.
  function automatic logic [GF_M-1:0] mul_apow(input logic [GF_M-1:0] v, input int p);
    logic [GF_M-1:0] r;
    r = v;
    for (int i = 0; i < p; i++) r = mulx(r);
    return r;
  endfunction

  // Horner step: shift the running value by one beat, then add this beat.
  always_comb begin
    acc_next = mul_apow(acc_in, BEAT_W * J);
    for (int k = 0; k < BEAT_W; k++)
      if (bits[k]) acc_next = acc_next ^ mul_apow(GF_M'(1), J * k);
  end
endmodule

module bch63_syndrome #(
  parameter int GF_M  = 6,
  parameter int N     = 63,
  parameter int BEATS = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [((N + 1) / BEATS)-1:0]    in_bits,
  output logic                            syn_valid,
  input  logic                            syn_ready,
  output logic [GF_M-1:0]                 s1,
  output logic [GF_M-1:0]                 s3,
  output logic                            err_flag
);
  localparam int BEAT_W  = (N + 1) / BEATS;
  localparam int CNT_W   = $clog2(BEATS);
  localparam int NUM_SYN = 2;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]                beat_cnt_q, beat_cnt_d;
  logic [NUM_SYN-1:0][GF_M-1:0]    acc_q, acc_d, acc_base, acc_next;
  logic                            syn_valid_q, syn_valid_d;
  logic [GF_M-1:0]                 s1_q, s1_d, s3_q, s3_d;
  logic                            err_q, err_d;
  logic [BEAT_W-1:0]               beat_bits;
  logic                            acc_fire, first_beat, last_fire;

  // Only the completing beat can stall, and only while the previous
  // result is still waiting; in_valid never feeds in_ready.
  assign in_ready   = ~((beat_cnt_q == LAST_BEAT) & syn_valid_q & ~syn_ready);
  assign acc_fire   = in_valid & in_ready;
  assign first_beat = (beat_cnt_q == '0);
  assign last_fire  = acc_fire & (beat_cnt_q == LAST_BEAT);

  // Beat 0 starts from a zero accumulator and carries only 63 - 56 = 7 bits.
  always_comb begin
    beat_bits = in_bits;
    acc_base  = acc_q;
    if (first_beat) begin
      beat_bits[BEAT_W-1] = 1'b0;
      acc_base            = '0;
    end
  end

  // Lane 0 evaluates at a (S1), lane 1 at a^3 (S3).
  for (genvar g = 0; g < NUM_SYN; g++) begin : g_lane
    bch63_syn_lane #(
      .J      (2 * g + 1),
      .GF_M   (GF_M),
      .BEAT_W (BEAT_W)
    ) u_lane (
      .bits     (beat_bits),
      .acc_in   (acc_base[g]),
      .acc_next (acc_next[g])
    );
  end

  // Beat counter and accumulators advance only on an accepted beat.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    acc_d      = acc_q;
    if (acc_fire) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
      acc_d      = acc_next;
    end
  end

  // Output slice: load on the completing beat, drop valid on handshake;
  // a simultaneous load wins so a back-to-back result is not lost.
  always_comb begin
    syn_valid_d = syn_valid_q;
    s1_d        = s1_q;
    s3_d        = s3_q;
    err_d       = err_q;
    if (last_fire) begin
      syn_valid_d = 1'b1;
      s1_d        = acc_next[0];
      s3_d        = acc_next[1];
      err_d       = |{acc_next[0], acc_next[1]};
    end else if (syn_ready) begin
      syn_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      syn_valid_q <= 1'b0;
      s1_q        <= '0;
      s3_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      acc_q       <= acc_d;
      syn_valid_q <= syn_valid_d;
      s1_q        <= s1_d;
      s3_q        <= s3_d;
      err_q       <= err_d;
    end
  end

  assign syn_valid = syn_valid_q;
  assign s1        = s1_q;
  assign s3        = s3_q;
  assign err_flag  = err_q;
endmodule

// File: doc/bch63_syndrome.md
Name: bch63_syndrome

Overview:
Downstream neighbour of the BCH input/fetch stage for the (63,51) t=2 binary BCH code. Consumes the hard-decision bits the fetch stage extracts from LLR sign bits, 8 per beat over 8 beats. Computes odd syndromes S1 = r(α) and S3 = r(α^3) over GF(2^6) with primitive polynomial x^6+x+1. Hands them to the error-locator stage via a valid/ready register slice.

Parameters:
GF_M, 6, field width; only default supported
N, 63, codeword length; only default supported
BEATS, 8, beats per codeword (8 bits/beat, first beat carries 7 bits)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  in_bits carries a beat
in_ready  output  1  beat accepted when in_valid & in_ready
in_bits  input  8  hard bits; beat b bit k is coefficient of x^(8*(7-b)+k); beat 0 bit 7 ignored (treated as 0)
syn_valid  output  1  s1/s3/err_flag valid
syn_ready  input  1  consumer accepts when syn_valid & syn_ready
s1  output  6  syndrome S1, polynomial basis, bit0 = α^0
s3  output  6  syndrome S3
err_flag  output  1  1 when s1 != 0 or s3 != 0

Behaviour:
- Reset (async, rst=1): beat_cnt=0, acc1=acc3=0, syn_valid=0, s1=s3=0, err_flag=0. in_ready=1 after reset.
- Accept condition: acc_fire = in_valid & in_ready.
- beat_cnt (3 bits) increments on each acc_fire, wraps 7->0. No other state machine; beat_cnt is the ACC phase index.
- Horner update on acc_fire, per syndrome j in {1,3}:
  - acc_j <= acc_j·α^(8j) + XOR over k=0..7 of in_bits[k]·α^(j·k).
  - Multiplication by constants is a fixed 6x6 GF(2) matrix; no general multiplier.
  - When beat_cnt==0, acc_j is treated as 0 (fresh start) and in_bits[7] is masked to 0.
- Final beat (beat_cnt==7 and acc_fire):
  - Next-state accumulator values load into s1/s3.
  - err_flag <= |{s1_next, s3_next}.
  - syn_valid <= 1.
  - Latency: first syndrome valid the cycle after the last beat's accepting edge.
- Output hold: syn_valid stays 1 and s1/s3/err_flag stay stable until syn_valid & syn_ready.
  - Then syn_valid <= 0, unless a new final beat is accepted in the same cycle, in which case syn_valid stays 1 with the new values.
- Backpressure: in_ready = ~(beat_cnt==7 & syn_valid & ~syn_ready).
  - Beats 0..6 of the next word are always accepted.
  - Only the completing beat stalls while the previous result is unconsumed.
  - in_ready is combinational on syn_ready; no path from in_valid to in_ready.
- Bubbles: in_valid low on any beat leaves beat_cnt and acc unchanged. Gaps are allowed anywhere.
- Reset mid-word: all accumulation is discarded. Next accepted beat is treated as beat 0.
- s1/s3 are not cleared on handshake; only syn_valid drops.

Test Plan:
- All-zero word, 8 consecutive beats, syn_ready=1 -> syn_valid pulses 1 cycle after beat 7; s1=6'h00, s3=6'h00, err_flag=0.
- Single 1 at degree 0 (beat 7 in_bits=8'h01, others 0) -> s1=6'b000001, s3=6'b000001, err_flag=1.
- Single 1 at degree 1 (beat 7 in_bits=8'h02) -> s1=6'b000010 (α), s3=6'b001000 (α^3).
- Single 1 at degree 62 (beat 0 in_bits=8'h40) -> s1=6'b100001 (α^62), s3=6'b111001 (α^60).
- Beat 0 in_bits=8'h80, rest 0 -> bit ignored, s1=s3=0, err_flag=0.
- Backpressure: hold syn_ready=0 after word A (degree-0 error) and stream word B (degree-1 error) with no gaps.
  -> B beats 0..6 accepted, in_ready=0 at B beat 7, s1 holds 6'b000001.
  -> Raise syn_ready: A consumed that cycle and B beat 7 accepted; next cycle s1=6'b000010, syn_valid=1.
- Assert rst after beat 4 of a degree-0-error word, then send a clean word -> s1=s3=0 and syn_valid asserts exactly once.
